// File: rtl/rat_rf_2w_pkg.sv
// Shared sizing defaults for the two-wide register file / rename table.
// RAT_RB is the register-index width derived from the register count.
package rat_rf_2w_pkg;
  localparam int RAT_XLEN     = 32;
  localparam int RAT_NREG     = 32;
  localparam int RAT_ROB_BITS = 3;
  localparam int RAT_RB       = $clog2(RAT_NREG);
endpackage

// File: rtl/rat_fwd_lookup.sv
// One source-operand lookup: the stored entry, patched by this cycle's commits,
// then by the older decode slot's rename when this port belongs to slot 1.
module rat_fwd_lookup
  import rat_rf_2w_pkg::*;
#(
  parameter int XLEN     = RAT_XLEN,
  parameter int ROB_BITS = RAT_ROB_BITS,
  parameter int RB       = RAT_RB
) (
  input  logic [RB-1:0]         q_id,
  input  logic [XLEN-1:0]       st_val,
  input  logic [ROB_BITS-1:0]   st_tag,
  input  logic                  st_busy,
  input  logic [1:0]            cm_en,
  input  logic [2*RB-1:0]       cm_id,
  input  logic [2*ROB_BITS-1:0] cm_tag,
  input  logic [2*XLEN-1:0]     cm_val,
  input  logic                  rn_en,
  input  logic [RB-1:0]         rn_id,
  input  logic [ROB_BITS-1:0]   rn_tag,
  output logic [XLEN-1:0]       f_val,
  output logic [ROB_BITS-1:0]   f_tag,
  output logic                  f_dep
);
  always_comb begin
    f_val = st_val;
    f_tag = st_tag;
    f_dep = st_busy;
    // Port 1 is visited last so the younger commit's value wins.
    for (int p = 0; p < 2; p++) begin
      if (cm_en[p] && (cm_id[p*RB +: RB] == q_id)) begin
        f_val = cm_val[p*XLEN +: XLEN];
        if (st_busy && (st_tag == cm_tag[p*ROB_BITS +: ROB_BITS])) f_dep = 1'b0;
      end
    end
    if (rn_en && (rn_id == q_id)) begin
      f_dep = 1'b1;
      f_tag = rn_tag;
    end
    if (q_id == '0) begin
      f_val = '0;
      f_tag = '0;
      f_dep = 1'b0;
    end
  end
endmodule

// File: rtl/rat_rf_2w.sv
// Two-wide architectural register file with per-register ROB dependency state:
// four forwarded source lookups, two renames and two in-order commits per cycle.
module rat_rf_2w
  import rat_rf_2w_pkg::*;
#(
  parameter int XLEN     = RAT_XLEN,
  parameter int NREG     = RAT_NREG,
  parameter int ROB_BITS = RAT_ROB_BITS,
  localparam int RB      = $clog2(NREG)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  rob_clear,
  input  logic [1:0]            cm_en,
  input  logic [2*RB-1:0]       cm_id,
  input  logic [2*ROB_BITS-1:0] cm_tag,
  input  logic [2*XLEN-1:0]     cm_val,
  input  logic [1:0]            rn_en,
  input  logic [2*RB-1:0]       rn_id,
  input  logic [2*ROB_BITS-1:0] rn_tag,
  input  logic [4*RB-1:0]       q_id,
  output logic [4*XLEN-1:0]     q_val,
  output logic [4*ROB_BITS-1:0] q_tag,
  output logic [3:0]            q_dep
);
  logic [NREG-1:0][XLEN-1:0]     val_q, val_d;
  logic [NREG-1:0][ROB_BITS-1:0] tag_q, tag_d;
  logic [NREG-1:0]               busy_q, busy_d;
  logic [1:0]                    cm_m, rn_m;

  // Register 0 is hardwired: any update aimed at it is dropped here.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      cm_m[p] = cm_en[p] && (cm_id[p*RB +: RB] != '0);
      rn_m[p] = rn_en[p] && (rn_id[p*RB +: RB] != '0);
    end
  end

  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    if (rdy_in) begin
      // Commits only ever compare against stored tags, so port order matters only for val.
      for (int p = 0; p < 2; p++) begin
        if (cm_m[p]) begin
          val_d[cm_id[p*RB +: RB]] = cm_val[p*XLEN +: XLEN];
          if (tag_q[cm_id[p*RB +: RB]] == cm_tag[p*ROB_BITS +: ROB_BITS])
            busy_d[cm_id[p*RB +: RB]] = 1'b0;
        end
      end
      if (rob_clear) begin
        busy_d = '0;
        tag_d  = '0;
      end else begin
        // Applied after commits so a rename overrides a same-cycle commit clear.
        for (int s = 0; s < 2; s++) begin
          if (rn_m[s]) begin
            tag_d[rn_id[s*RB +: RB]]  = rn_tag[s*ROB_BITS +: ROB_BITS];
            busy_d[rn_id[s*RB +: RB]] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      val_q  <= '0;
      tag_q  <= '0;
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_lookup
    logic [RB-1:0] id;
    assign id = q_id[i*RB +: RB];
    rat_fwd_lookup #(.XLEN(XLEN), .ROB_BITS(ROB_BITS), .RB(RB)) u_lookup (
      .q_id    (id),
      .st_val  (val_q[id]),
      .st_tag  (tag_q[id]),
      .st_busy (busy_q[id]),
      .cm_en   (cm_m),
      .cm_id   (cm_id),
      .cm_tag  (cm_tag),
      .cm_val  (cm_val),
      .rn_en   ((i >= 2) ? rn_m[0] : 1'b0),
      .rn_id   (rn_id[RB-1:0]),
      .rn_tag  (rn_tag[ROB_BITS-1:0]),
      .f_val   (q_val[i*XLEN +: XLEN]),
      .f_tag   (q_tag[i*ROB_BITS +: ROB_BITS]),
      .f_dep   (q_dep[i])
    );
  end
endmodule

// File: tb/tb_rat_rf_2w.sv
// Directed bench for rat_rf_2w: hand-computed expectations checked with
// immediate assertions, one linear sequence of steps.
module tb_rat_rf_2w;
  localparam int XLEN = 32;
  localparam int RB   = 5;
  localparam int TB   = 3;

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              rdy_in;
  logic              rob_clear;
  logic [1:0]        cm_en;
  logic [2*RB-1:0]   cm_id;
  logic [2*TB-1:0]   cm_tag;
  logic [2*XLEN-1:0] cm_val;
  logic [1:0]        rn_en;
  logic [2*RB-1:0]   rn_id;
  logic [2*TB-1:0]   rn_tag;
  logic [4*RB-1:0]   q_id;
  logic [4*XLEN-1:0] q_val;
  logic [4*TB-1:0]   q_tag;
  logic [3:0]        q_dep;

  int n_vec = 0;
  int n_err = 0;

  rat_rf_2w #(.XLEN(XLEN), .NREG(32), .ROB_BITS(TB)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .cm_en(cm_en), .cm_id(cm_id), .cm_tag(cm_tag), .cm_val(cm_val),
    .rn_en(rn_en), .rn_id(rn_id), .rn_tag(rn_tag),
    .q_id(q_id), .q_val(q_val), .q_tag(q_tag), .q_dep(q_dep)
  );

  always #5 clk_in = ~clk_in;

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    rdy_in = 1'b1; rob_clear = 1'b0;
    cm_en = '0; cm_id = '0; cm_tag = '0; cm_val = '0;
    rn_en = '0; rn_id = '0; rn_tag = '0; q_id = '0;
  endtask

  task automatic set_q(input int i, input logic [RB-1:0] id);
    q_id[i*RB +: RB] = id;
  endtask

  task automatic commit(input int p, input logic [RB-1:0] id, input logic [TB-1:0] tg,
                        input logic [XLEN-1:0] v);
    cm_en[p] = 1'b1;
    cm_id[p*RB +: RB] = id;
    cm_tag[p*TB +: TB] = tg;
    cm_val[p*XLEN +: XLEN] = v;
  endtask

  task automatic rename(input int s, input logic [RB-1:0] id, input logic [TB-1:0] tg);
    rn_en[s] = 1'b1;
    rn_id[s*RB +: RB] = id;
    rn_tag[s*TB +: TB] = tg;
  endtask

  task automatic chk(input string name, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic chk_val(input string name, input int i, input logic [XLEN-1:0] exp);
    chk({name, ".val"}, q_val[i*XLEN +: XLEN], exp);
  endtask

  task automatic chk_dep(input string name, input int i, input logic exp);
    chk({name, ".dep"}, {31'b0, q_dep[i]}, {31'b0, exp});
  endtask

  task automatic chk_tag(input string name, input int i, input logic [TB-1:0] exp);
    chk({name, ".tag"}, {29'b0, q_tag[i*TB +: TB]}, {29'b0, exp});
  endtask

  initial begin
    idle();
    rst_in = 1'b1;
    tick(); tick();
    rst_in = 1'b0;
    #2;
    chk_val("rst_q0", 0, 32'h0);
    chk_tag("rst_q0", 0, 3'd0);
    chk_dep("rst_q0", 0, 1'b0);
    set_q(0, 5'd5); #2;
    chk_val("rst_x5", 0, 32'h0);
    chk_dep("rst_x5", 0, 1'b0);

    // Updates to x0 are ignored, including forwarding.
    tick(); idle();
    commit(0, 5'd0, 3'd0, 32'd7); rename(0, 5'd0, 3'd3);
    set_q(0, 5'd0); set_q(2, 5'd0); #2;
    chk_val("x0_fwd", 0, 32'h0);
    chk_dep("x0_fwd_s1", 2, 1'b0);
    tick(); idle(); #2;
    chk_val("x0_after", 0, 32'h0);
    chk_dep("x0_after", 0, 1'b0);

    // Slot-0 rename of x3 is visible to slot 1 only.
    tick(); idle();
    rename(0, 5'd3, 3'd2); set_q(0, 5'd3); set_q(2, 5'd3); #2;
    chk_dep("rn_s1", 2, 1'b1);
    chk_tag("rn_s1", 2, 3'd2);
    chk_dep("rn_s0", 0, 1'b0);
    tick(); idle(); set_q(0, 5'd3); #2;
    chk_dep("x3_busy", 0, 1'b1);
    chk_tag("x3_busy", 0, 3'd2);

    // Matching commit forwards value and clears dependency.
    tick(); idle();
    commit(0, 5'd3, 3'd2, 32'h55); set_q(0, 5'd3); #2;
    chk_val("cm_fwd", 0, 32'h55);
    chk_dep("cm_fwd", 0, 1'b0);
    tick(); idle(); set_q(0, 5'd3); #2;
    chk_val("cm_after", 0, 32'h55);
    chk_dep("cm_after", 0, 1'b0);

    // Commit and rename of x3 together: rename wins.
    tick(); idle(); rename(0, 5'd3, 3'd2);
    tick(); idle();
    commit(0, 5'd3, 3'd2, 32'h55); rename(0, 5'd3, 3'd5); set_q(2, 5'd3); #2;
    chk_val("cmrn_fwd", 2, 32'h55);
    chk_dep("cmrn_fwd", 2, 1'b1);
    chk_tag("cmrn_fwd", 2, 3'd5);
    tick(); idle(); set_q(0, 5'd3); #2;
    chk_val("cmrn_after", 0, 32'h55);
    chk_dep("cmrn_after", 0, 1'b1);
    chk_tag("cmrn_after", 0, 3'd5);

    // Full-ROB wrap: commit tag equals the new rename tag, stays busy.
    tick(); idle();
    commit(1, 5'd3, 3'd5, 32'h66); rename(1, 5'd3, 3'd5);
    tick(); idle(); set_q(0, 5'd3); #2;
    chk_val("wrap", 0, 32'h66);
    chk_dep("wrap", 0, 1'b1);

    // Double rename of x4 (slot 1 wins), then double commit (port 1 matches).
    tick(); idle();
    rename(0, 5'd4, 3'd1); rename(1, 5'd4, 3'd4);
    tick(); idle(); set_q(1, 5'd4); #2;
    chk_dep("x4_busy", 1, 1'b1);
    chk_tag("x4_busy", 1, 3'd4);
    tick(); idle();
    commit(0, 5'd4, 3'd1, 32'd10); commit(1, 5'd4, 3'd4, 32'd20); set_q(1, 5'd4); #2;
    chk_val("dcm_fwd", 1, 32'd20);
    chk_dep("dcm_fwd", 1, 1'b0);
    tick(); idle(); set_q(1, 5'd4); #2;
    chk_val("dcm_after", 1, 32'd20);
    chk_dep("dcm_after", 1, 1'b0);

    // Double rename of x6: slot 1 query sees only slot 0's tag this cycle.
    tick(); idle();
    rename(0, 5'd6, 3'd1); rename(1, 5'd6, 3'd6); set_q(3, 5'd6); #2;
    chk_tag("drn_fwd", 3, 3'd1);
    tick(); idle(); set_q(3, 5'd6); #2;
    chk_dep("drn_after", 3, 1'b1);
    chk_tag("drn_after", 3, 3'd6);

    // rob_clear with commit of x7 and rename of x8.
    tick(); idle();
    rob_clear = 1'b1; commit(0, 5'd7, 3'd0, 32'd9); rename(0, 5'd8, 3'd3);
    set_q(0, 5'd3); set_q(2, 5'd8); #2;
    chk_dep("clr_fwd_x3", 0, 1'b1);
    chk_dep("clr_fwd_x8", 2, 1'b1);
    tick(); idle();
    set_q(0, 5'd3); set_q(1, 5'd7); set_q(2, 5'd8); set_q(3, 5'd6); #2;
    chk_dep("clr_x3", 0, 1'b0);
    chk_val("clr_x7", 1, 32'd9);
    chk_dep("clr_x8", 2, 1'b0);
    chk_dep("clr_x6", 3, 1'b0);

    // rdy_in low freezes state but forwarding still operates.
    tick(); idle(); rename(0, 5'd9, 3'd7);
    tick(); idle();
    rdy_in = 1'b0; rob_clear = 1'b1;
    commit(0, 5'd7, 3'd0, 32'h99); commit(1, 5'd9, 3'd7, 32'h11); rename(0, 5'd10, 3'd1);
    set_q(0, 5'd7); #2;
    chk_val("hold_fwd", 0, 32'h99);
    tick(); idle();
    set_q(0, 5'd7); set_q(1, 5'd9); set_q(2, 5'd10); #2;
    chk_val("hold_x7", 0, 32'd9);
    chk_dep("hold_x9", 1, 1'b1);
    chk_tag("hold_x9", 1, 3'd7);
    chk_dep("hold_x10", 2, 1'b0);

    // Asynchronous reset clears state without a clock edge.
    #1 rst_in = 1'b1; #1;
    chk_val("arst_x7", 0, 32'h0);
    chk_dep("arst_x9", 1, 1'b0);
    rst_in = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
